// File: rtl/cpu_bus_controller.sv
// cpu_bus_controller
// Memory-side responder for the cpu core bus. Services cpu reads and writes
// from a 2**RAM_ADDR_WIDTH byte work RAM mirrored across 0x0000-0x1FFF and
// forwards every other address to a single external req/ack port.
//
// Ports
//   clock_i, reset_n_i        clock, asynchronous active-low reset
//   cpu_address_i/_valid_i    cpu address and its qualifier
//   cpu_wdata_i, cpu_write_i  cpu write byte; cpu_write_i high = write cycle
//   cpu_rdata_o/_valid_o      returned byte; valid held until the next start
//   ext_req_o/_we_o           external request (held until ack) and direction
//   ext_address_o/_wdata_o    external address / write byte, stable while req
//   ext_rdata_i, ext_ack_i    external read byte, valid with one-cycle ack
//   timeout_o                 sticky external timeout flag
//
// Optional feature: define BUS_TIMEOUT_EN to abandon an external request after
// TIMEOUT_CYCLES cycles without ack, completing with the last read byte
// (open bus). Without it the external wait is unbounded and timeout_o is 0.
module cpu_bus_controller #(
    parameter int unsigned RAM_ADDR_WIDTH = 11,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic [15:0] cpu_address_i,
    input  logic        cpu_address_valid_i,
    input  logic [7:0]  cpu_wdata_i,
    input  logic        cpu_write_i,
    output logic [7:0]  cpu_rdata_o,
    output logic        cpu_rdata_valid_o,
    output logic        ext_req_o,
    output logic        ext_we_o,
    output logic [15:0] ext_address_o,
    output logic [7:0]  ext_wdata_o,
    input  logic [7:0]  ext_rdata_i,
    input  logic        ext_ack_i,
    output logic        timeout_o
);

    localparam int unsigned RAM_DEPTH = 1 << RAM_ADDR_WIDTH;
    localparam logic [15:0] RAM_LIMIT = 16'h2000;

    typedef enum logic [1:0] {IDLE, RAM, EXT, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic        cpu_rdata_valid_q, cpu_rdata_valid_d;
    logic        ext_req_q, ext_req_d;
    logic        ext_we_q, ext_we_d;
    logic [15:0] ext_address_q, ext_address_d;
    logic [7:0]  ext_wdata_q, ext_wdata_d;
    logic [7:0]  open_bus_q, open_bus_d;
    logic [15:0] svc_addr_q, svc_addr_d;
    logic        svc_write_q, svc_write_d;
    logic        svc_seen_q, svc_seen_d;

    logic [7:0]  ram_mem [RAM_DEPTH];
    logic [7:0]  ram_rdata_q;
    logic        ram_en;
    logic        ram_we;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;

    logic        start;
    logic        cmpl;
    logic [7:0]  cmpl_data;
    logic        cmpl_read;
    logic        may_start;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    // A new transaction is any valid cycle whose {address, write} pair differs
    // from the last one serviced; svc_seen_q forces the first one after reset
    // so the reset-vector fetch is serviced even if it matches the cleared pair.
    assign start = cpu_address_valid_i &&
                   (!svc_seen_q || (cpu_address_i != svc_addr_q) ||
                    (cpu_write_i != svc_write_q));

    // The mirror falls out of ignoring the upper address bits.
    assign ram_idx = cpu_address_i[RAM_ADDR_WIDTH-1:0];

    always_comb begin
        state_d           = state_q;
        cpu_rdata_d       = cpu_rdata_q;
        cpu_rdata_valid_d = cpu_rdata_valid_q;
        ext_req_d         = ext_req_q;
        ext_we_d          = ext_we_q;
        ext_address_d     = ext_address_q;
        ext_wdata_d       = ext_wdata_q;
        open_bus_d        = open_bus_q;
        svc_addr_d        = svc_addr_q;
        svc_write_d       = svc_write_q;
        svc_seen_d        = svc_seen_q;
        ram_en            = 1'b0;
        ram_we            = 1'b0;
        cmpl              = 1'b0;
        cmpl_data         = 8'h00;
        cmpl_read         = 1'b0;
        may_start         = 1'b0;
`ifdef BUS_TIMEOUT_EN
        cnt_d             = cnt_q;
        timeout_d         = timeout_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                may_start = 1'b1;
            end
            RAM: begin
                cmpl      = 1'b1;
                cmpl_data = ram_rdata_q;
                cmpl_read = !svc_write_q;
            end
            EXT: begin
                if (ext_ack_i) begin
                    cmpl      = 1'b1;
                    // Writes hand back the byte that was written.
                    cmpl_data = svc_write_q ? ext_wdata_q : ext_rdata_i;
                    cmpl_read = !svc_write_q;
                end
`ifdef BUS_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    cmpl      = 1'b1;
                    cmpl_data = open_bus_q;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An in-flight access always runs to completion. If the cpu moved on
        // meanwhile, the result is dropped and the new access starts at once,
        // leaving cpu_rdata_valid_o low throughout.
        if (cmpl) begin
            ext_req_d = 1'b0;
            if (start) begin
                may_start = 1'b1;
            end else begin
                state_d           = DONE;
                cpu_rdata_valid_d = 1'b1;
                cpu_rdata_d       = cmpl_data;
                if (cmpl_read) begin
                    open_bus_d = cmpl_data;
                end
            end
        end

        if (may_start && start) begin
            svc_seen_d        = 1'b1;
            svc_addr_d        = cpu_address_i;
            svc_write_d       = cpu_write_i;
            cpu_rdata_valid_d = 1'b0;
            if (cpu_address_i < RAM_LIMIT) begin
                state_d = RAM;
                ram_en  = 1'b1;
                ram_we  = cpu_write_i;
            end else begin
                state_d       = EXT;
                ext_req_d     = 1'b1;
                ext_we_d      = cpu_write_i;
                ext_address_d = cpu_address_i;
                ext_wdata_d   = cpu_wdata_i;
`ifdef BUS_TIMEOUT_EN
                cnt_d         = '0;
`endif
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q           <= IDLE;
            cpu_rdata_q       <= 8'h00;
            cpu_rdata_valid_q <= 1'b0;
            ext_req_q         <= 1'b0;
            ext_we_q          <= 1'b0;
            ext_address_q     <= 16'h0000;
            ext_wdata_q       <= 8'h00;
            open_bus_q        <= 8'h00;
            svc_addr_q        <= 16'h0000;
            svc_write_q       <= 1'b0;
            svc_seen_q        <= 1'b0;
        end else begin
            state_q           <= state_d;
            cpu_rdata_q       <= cpu_rdata_d;
            cpu_rdata_valid_q <= cpu_rdata_valid_d;
            ext_req_q         <= ext_req_d;
            ext_we_q          <= ext_we_d;
            ext_address_q     <= ext_address_d;
            ext_wdata_q       <= ext_wdata_d;
            open_bus_q        <= open_bus_d;
            svc_addr_q        <= svc_addr_d;
            svc_write_q       <= svc_write_d;
            svc_seen_q        <= svc_seen_d;
        end
    end

    // Work RAM: write lands in the start cycle; the read port is loaded in the
    // same cycle (with the written byte on a write) and consumed one cycle later.
    always_ff @(posedge clock_i) begin
        if (ram_en) begin
            if (ram_we) begin
                ram_mem[ram_idx] <= cpu_wdata_i;
                ram_rdata_q      <= cpu_wdata_i;
            end else begin
                ram_rdata_q      <= ram_mem[ram_idx];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    // Open bus only feeds the timeout completion; keep it visible as used.
    logic unused_cfg;
    assign unused_cfg = ^{open_bus_q, TIMEOUT_CYCLES};
    assign timeout_o  = 1'b0;
`endif

    assign cpu_rdata_o       = cpu_rdata_q;
    assign cpu_rdata_valid_o = cpu_rdata_valid_q;
    assign ext_req_o         = ext_req_q;
    assign ext_we_o          = ext_we_q;
    assign ext_address_o     = ext_address_q;
    assign ext_wdata_o       = ext_wdata_q;

endmodule

// File: tb/tb_cpu_bus_controller.sv
// Testbench for cpu_bus_controller: directed boundary cases plus randomized
// cpu traffic checked against a transaction-level model (byte array RAM,
// last-serviced pair, expected held output).
module tb_cpu_bus_controller;

    localparam int TO_CYC = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic        cpu_avalid;
    logic [7:0]  cpu_wdata;
    logic        cpu_write;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic        ext_req;
    logic        ext_we;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;
    logic        ext_ack;
    logic        timeout;

    always #5 clk = ~clk;

    cpu_bus_controller #(
        .RAM_ADDR_WIDTH(11),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clock_i            (clk),
        .reset_n_i          (rst_n),
        .cpu_address_i      (cpu_addr),
        .cpu_address_valid_i(cpu_avalid),
        .cpu_wdata_i        (cpu_wdata),
        .cpu_write_i        (cpu_write),
        .cpu_rdata_o        (cpu_rdata),
        .cpu_rdata_valid_o  (cpu_rvalid),
        .ext_req_o          (ext_req),
        .ext_we_o           (ext_we),
        .ext_address_o      (ext_addr),
        .ext_wdata_o        (ext_wdata),
        .ext_rdata_i        (ext_rdata),
        .ext_ack_i          (ext_ack),
        .timeout_o          (timeout)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  ref_ram [2048];
    bit          ref_known [2048];
    logic [16:0] last_pair;
    bit          have_last;
    logic [7:0]  exp_rdata;
    logic        exp_valid;
    logic        exp_timeout;
`ifdef BUS_TIMEOUT_EN
    logic [7:0]  ref_open_bus;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        have_last   = 1'b0;
        last_pair   = '0;
        exp_rdata   = 8'h00;
        exp_valid   = 1'b0;
        exp_timeout = 1'b0;
`ifdef BUS_TIMEOUT_EN
        ref_open_bus = 8'h00;
`endif
    endtask

    // Entered and left at a falling edge; drives the cpu side and plays the
    // external responder with the requested ack delay.
    task automatic do_txn(input logic [15:0] a, input logic w, input logic [7:0] d,
                          input int ack_dly, input logic [7:0] ack_data);
        logic [7:0] exp;
        cpu_addr   = a;
        cpu_write  = w;
        cpu_wdata  = d;
        cpu_avalid = 1'b1;
        if (have_last && last_pair == {a, w}) begin
            repeat (2) begin
                @(negedge clk);
                check("same_pair_valid", cpu_rvalid, exp_valid);
                check("same_pair_rdata", cpu_rdata, exp_rdata);
            end
            return;
        end
        have_last = 1'b1;
        last_pair = {a, w};
        if (a < 16'h2000) begin
            if (w) begin
                ref_ram[a[10:0]]   = d;
                ref_known[a[10:0]] = 1'b1;
                exp = d;
            end else begin
                exp = ref_ram[a[10:0]];
            end
            @(negedge clk);
            check("ram_busy", cpu_rvalid, 1'b0);
            @(negedge clk);
        end else begin
            @(negedge clk);
            check("ext_req", ext_req, 1'b1);
            check("ext_addr", ext_addr, a);
            check("ext_we", ext_we, w);
            if (w) check("ext_wdata", ext_wdata, d);
            check("ext_busy", cpu_rvalid, 1'b0);
            for (int i = 0; i < ack_dly; i++) begin
                @(negedge clk);
                check("ext_wait_req", ext_req, 1'b1);
            end
            ext_ack   = 1'b1;
            ext_rdata = ack_data;
            @(negedge clk);
            ext_ack   = 1'b0;
            ext_rdata = 8'($urandom);
            check("ext_req_drop", ext_req, 1'b0);
            exp = w ? d : ack_data;
        end
`ifdef BUS_TIMEOUT_EN
        if (!w) ref_open_bus = exp;
`endif
        exp_valid = 1'b1;
        exp_rdata = exp;
        check("done_valid", cpu_rvalid, 1'b1);
        check("done_rdata", cpu_rdata, exp);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic        w;
        logic [7:0]  d;
        int          kind;

        rst_n      = 1'b0;
        cpu_addr   = 16'h0000;
        cpu_avalid = 1'b0;
        cpu_wdata  = 8'h00;
        cpu_write  = 1'b0;
        ext_rdata  = 8'h00;
        ext_ack    = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        check("rst_valid", cpu_rvalid, 1'b0);
        check("rst_rdata", cpu_rdata, 8'h00);
        check("rst_req", ext_req, 1'b0);
        check("rst_we", ext_we, 1'b0);
        check("rst_addr", ext_addr, 16'h0000);
        check("rst_wdata", ext_wdata, 8'h00);
        check("rst_timeout", timeout, 1'b0);

        // Reset-vector fetch right after release; ack two cycles after request
        rst_n = 1'b1;
        do_txn(16'hFFFC, 1'b0, 8'h00, 1, 8'h34);
        check("vector_rdata", cpu_rdata, 8'h34);

        // Populate RAM indices 0..63 and 0x300
        for (int i = 0; i < 64; i++) do_txn(16'(i), 1'b1, 8'($urandom), 0, 8'h00);
        do_txn(16'h0300, 1'b1, 8'hB7, 0, 8'h00);

        // Single write, repeated strobe with new data must not write again
        do_txn(16'h0012, 1'b1, 8'h5A, 0, 8'h00);
        do_txn(16'h0012, 1'b1, 8'hA5, 0, 8'h00);
        do_txn(16'h0812, 1'b0, 8'h00, 0, 8'h00);
        check("mirror_0812", cpu_rdata, 8'h5A);

        // Mirrors of 0x0000
        do_txn(16'h0000, 1'b1, 8'hC3, 0, 8'h00);
        do_txn(16'h0800, 1'b0, 8'h00, 0, 8'h00);
        do_txn(16'h1000, 1'b0, 8'h00, 0, 8'h00);
        do_txn(16'h1800, 1'b0, 8'h00, 0, 8'h00);
        check("mirror_1800", cpu_rdata, 8'hC3);

        // Held address: one transaction, stray ack ignored
        do_txn(16'h0300, 1'b0, 8'h00, 0, 8'h00);
        for (int i = 0; i < 12; i++) begin
            ext_ack   = (i == 4);
            ext_rdata = 8'hEE;
            @(negedge clk);
            check("hold_valid", cpu_rvalid, 1'b1);
            check("hold_rdata", cpu_rdata, 8'hB7);
        end
        ext_ack = 1'b0;

        // Address change during EXT: 0x99 discarded, 0x0001 serviced
        cpu_addr = 16'h8000; cpu_write = 1'b0; cpu_avalid = 1'b1;
        @(negedge clk);
        check("abort_ext_req", ext_req, 1'b1);
        cpu_addr = 16'h0001;
        @(negedge clk);
        check("abort_ext_busy", cpu_rvalid, 1'b0);
        check("abort_ext_addr", ext_addr, 16'h8000);
        ext_ack = 1'b1; ext_rdata = 8'h99;
        @(negedge clk);
        ext_ack = 1'b0;
        check("abort_ext_discard", cpu_rvalid, 1'b0);
        check("abort_ext_req_drop", ext_req, 1'b0);
        @(negedge clk);
        check("abort_ext_valid", cpu_rvalid, 1'b1);
        check("abort_ext_rdata", cpu_rdata, ref_ram[1]);
        have_last = 1'b1; last_pair = {16'h0001, 1'b0};
        exp_valid = 1'b1; exp_rdata = ref_ram[1];
`ifdef BUS_TIMEOUT_EN
        ref_open_bus = ref_ram[1];
`endif

        // Address change during RAM: 0x0010 discarded, 0x0020 serviced
        cpu_addr = 16'h0010;
        @(negedge clk);
        check("abort_ram_busy", cpu_rvalid, 1'b0);
        cpu_addr = 16'h0020;
        @(negedge clk);
        check("abort_ram_discard", cpu_rvalid, 1'b0);
        @(negedge clk);
        check("abort_ram_valid", cpu_rvalid, 1'b1);
        check("abort_ram_rdata", cpu_rdata, ref_ram[32]);
        last_pair = {16'h0020, 1'b0};
        exp_rdata = ref_ram[32];
`ifdef BUS_TIMEOUT_EN
        ref_open_bus = ref_ram[32];

        // No ack: after TO_CYC cycles complete with open bus and flag timeout
        do_txn(16'h4010, 1'b0, 8'h00, 0, 8'h77);
        cpu_addr = 16'h4020;
        @(negedge clk);
        check("to_req", ext_req, 1'b1);
        for (int i = 1; i < TO_CYC; i++) begin
            @(negedge clk);
            check("to_wait_req", ext_req, 1'b1);
            check("to_wait_flag", timeout, 1'b0);
        end
        @(negedge clk);
        check("to_req_drop", ext_req, 1'b0);
        check("to_valid", cpu_rvalid, 1'b1);
        check("to_rdata", cpu_rdata, ref_open_bus);
        check("to_flag", timeout, 1'b1);
        last_pair   = {16'h4020, 1'b0};
        exp_rdata   = ref_open_bus;
        exp_timeout = 1'b1;
`endif

        // Reset mid-EXT: outputs clear before the next rising edge
        cpu_addr = 16'h6000; cpu_write = 1'b0; cpu_avalid = 1'b1;
        @(negedge clk);
        check("rst_mid_req_before", ext_req, 1'b1);
        check("timeout_before_rst", timeout, exp_timeout);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_req", ext_req, 1'b0);
        check("rst_mid_valid", cpu_rvalid, 1'b0);
        check("rst_mid_timeout", timeout, 1'b0);
        check("rst_mid_rdata", cpu_rdata, 8'h00);
        cpu_avalid = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(16'hFFFC, 1'b0, 8'h00, 1, 8'h34);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                do_txn(last_pair[16:1], last_pair[0], 8'($urandom), 0, 8'h00);
            end else if (kind <= 4) begin
                a = 16'(($urandom_range(0, 3) << 11) + $urandom_range(0, 63));
                w = 1'($urandom);
                if (!ref_known[a[10:0]]) w = 1'b1;
                do_txn(a, w, 8'($urandom), 0, 8'h00);
            end else if (kind <= 8) begin
                a = 16'(16'h2000 + $urandom_range(0, 16'hDFFF));
                w = 1'($urandom);
                d = 8'($urandom);
                do_txn(a, w, d, int'($urandom_range(0, 4)), 8'($urandom));
            end else begin
                cpu_avalid = 1'b0;
                cpu_addr   = 16'($urandom);
                cpu_write  = 1'($urandom);
                @(negedge clk);
                ext_ack   = 1'b1;
                ext_rdata = 8'($urandom);
                @(negedge clk);
                ext_ack = 1'b0;
                check("idle_valid", cpu_rvalid, exp_valid);
                check("idle_rdata", cpu_rdata, exp_rdata);
                check("idle_req", ext_req, 1'b0);
                @(negedge clk);
                check("idle_valid2", cpu_rvalid, exp_valid);
                check("idle_rdata2", cpu_rdata, exp_rdata);
            end
        end
        check("final_timeout", timeout, exp_timeout);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
